// File: rtl/count_uart_reporter.sv
// count_uart_reporter: reports every new 4-bit counter value over a UART TX line
// as one uppercase ASCII hex digit, optionally followed by CR LF (8N1 frames).
module count_uart_reporter #(
   parameter int unsigned BAUD_DIV = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] count_in,
   input  logic       force_send,
   input  logic       crlf_en,
   input  logic       clr_ovr,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

   localparam int unsigned DIV_W = 12;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             ovr_q, ovr_d;
   logic [3:0]       last_q, last_d;
   logic             pend_q, pend_d;
   logic [3:0]       prev_q;
   logic             crlf_q, crlf_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       chr_q, chr_d;

   logic [7:0]       cur_byte;
   logic             div_end;
   logic             changed;
   logic             last_char;

   // Hex nibble to uppercase ASCII
   function automatic logic [7:0] hex_ascii(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
   endfunction

   // Character currently being framed: digit, then CR, then LF
   always_comb begin
      case (chr_q)
         2'd0:    cur_byte = hex_ascii(last_q);
         2'd1:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   assign div_end   = (div_q == DIV_LAST);
   assign changed   = (count_in != prev_q);
   assign last_char = !crlf_q || (chr_q == 2'd2);

   // Next-state, framing and pending/overrun bookkeeping
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      ovr_d   = ovr_q;
      last_d  = last_q;
      pend_d  = pend_q;
      crlf_d  = crlf_q;
      div_d   = div_q;
      bit_d   = bit_q;
      chr_d   = chr_q;

      if (clr_ovr) begin
         ovr_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (pend_q || (count_in != last_q) || force_send) begin
               last_d  = count_in;
               crlf_d  = crlf_en;
               pend_d  = 1'b0;
               chr_d   = 2'd0;
               div_d   = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (div_end) begin
               div_d   = '0;
               bit_d   = '0;
               tx_d    = cur_byte[0];
               state_d = S_DATA;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (div_end) begin
               div_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (div_end) begin
               div_d = '0;
               if (last_char) begin
                  state_d = S_DONE;
               end else begin
                  chr_d   = chr_q + 2'd1;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // A value seen while a message is in flight is remembered; a second one is lost
      if (state_q != S_IDLE) begin
         if (changed || force_send) begin
            pend_d = 1'b1;
         end
         if (changed && pend_q) begin
            ovr_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         last_q  <= '0;
         pend_q  <= 1'b0;
         prev_q  <= '0;
         crlf_q  <= 1'b0;
         div_q   <= '0;
         bit_q   <= '0;
         chr_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         prev_q  <= count_in;
         crlf_q  <= crlf_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         chr_q   <= chr_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Bench for count_uart_reporter: directed and randomized counter updates, UART
// frames decoded from tx and compared with an expected-message queue.
module tb_count_uart_reporter;

   localparam int unsigned B = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] count_in;
   logic       force_send;
   logic       crlf_en;
   logic       clr_ovr;
   logic       tx;
   logic       busy;
   logic       overrun;

   int checks;
   int errors;
   logic [7:0] exp_q[$];

   count_uart_reporter #(.BAUD_DIV(B)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_in   (count_in),
      .force_send (force_send),
      .crlf_en    (crlf_en),
      .clr_ovr    (clr_ovr),
      .tx         (tx),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: digit as ASCII, uppercase letters for 10..15
   function automatic logic [7:0] hex_char(input logic [3:0] v);
      int n;
      n = int'(v);
      if (n < 10) return 8'(48 + n);
      return 8'(65 + n - 10);
   endfunction

   task automatic expect_msg(input logic [3:0] v, input logic crlf);
      exp_q.push_back(hex_char(v));
      if (crlf) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   // Decode one 8N1 frame; entered at a negedge, leaves at the last stop-bit negedge
   task automatic rx_frame(output logic [7:0] b, output int waited, output logic ok);
      logic [9:0] bits;
      waited = 0;
      ok = 1'b1;
      b = 8'h00;
      bits = '0;
      while (tx !== 1'b0 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < int'(B); j++) begin
            if (j == 0) bits[i] = tx;
            else if (tx !== bits[i]) ok = 1'b0;
            if (!(i == 9 && j == int'(B) - 1)) @(negedge clk);
         end
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      b = bits[8:1];
   endtask

   // Receive every queued character; first start bit expected exp_wait cycles in
   task automatic recv_msg(input string tag, input int exp_wait);
      int n;
      logic [7:0] b;
      int w;
      logic ok;
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         rx_frame(b, w, ok);
         chk($sformatf("%s_gap%0d", tag, k), 32'(w), 32'((k == 0) ? exp_wait : 0));
         chk($sformatf("%s_frame%0d", tag, k), 32'(ok), 32'd1);
         chk($sformatf("%s_byte%0d", tag, k), 32'(b), 32'(exp_q.pop_front()));
         @(negedge clk);
      end
      chk($sformatf("%s_done_tx", tag), 32'(tx), 32'd1);
      chk($sformatf("%s_done_busy", tag), 32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [3:0] v;
      logic [3:0] cur;
      logic       c;
      int         w;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      count_in = 4'd0;
      force_send = 1'b0;
      crlf_en = 1'b0;
      clr_ovr = 1'b0;

      // Reset values
      #12;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Count equal to reset last_sent: nothing sent
      quiet("idle100", 100);

      // 0 -> 5, digit only, start bit one cycle after the change
      count_in = 4'd5;
      expect_msg(4'd5, 1'b0);
      recv_msg("m5", 1);

      // 0xB with CR LF; crlf_en dropped mid-message
      count_in = 4'hB;
      crlf_en = 1'b1;
      expect_msg(4'hB, 1'b1);
      fork
         recv_msg("mB", 1);
         begin
            repeat (20) @(negedge clk);
            crlf_en = 1'b0;
         end
      join

      // Single change while busy: one follow-up message, no overrun
      count_in = 4'd5;
      expect_msg(4'd5, 1'b0);
      fork
         recv_msg("p1", 1);
         begin
            repeat (10) @(negedge clk);
            count_in = 4'd6;
         end
      join
      chk("p1_ovr", 32'(overrun), 32'd0);
      expect_msg(4'd6, 1'b0);
      fork
         recv_msg("p2", 1);
         begin
            repeat (8) @(negedge clk);
            count_in = 4'd7;
            repeat (8) @(negedge clk);
            count_in = 4'd8;
         end
      join
      chk("p2_ovr", 32'(overrun), 32'd1);
      expect_msg(4'd8, 1'b0);
      recv_msg("p3", 1);
      repeat (5) @(negedge clk);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);

      // force_send with unchanged count
      count_in = 4'd3;
      expect_msg(4'd3, 1'b0);
      recv_msg("f0", 1);
      force_send = 1'b1;
      @(negedge clk);
      force_send = 1'b0;
      expect_msg(4'd3, 1'b0);
      recv_msg("f1", 0);

      // force_send together with a change: exactly one message
      v = 4'($urandom_range(15));
      while (v == 4'd3 || v == 4'hA) v = v + 4'd1;
      count_in = v;
      force_send = 1'b1;
      @(negedge clk);
      force_send = 1'b0;
      expect_msg(v, 1'b0);
      recv_msg("f2", 0);
      quiet("f2_single", 60);

      // Reset in the middle of the data bits of 'A'
      count_in = 4'hA;
      w = 0;
      while (tx !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ra_start", 32'(tx), 32'd0);
      repeat (3 * B) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ra_tx", 32'(tx), 32'd1);
      chk("ra_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_msg(4'hA, 1'b0);
      recv_msg("ra_fresh", 1);

      // Randomized updates, optionally with one change while busy
      cur = 4'hA;
      for (int it = 0; it < 8; it++) begin
         v = 4'($urandom_range(15));
         if (v == cur) v = v + 4'd1;
         c = 1'($urandom_range(1));
         crlf_en = c;
         count_in = v;
         cur = v;
         expect_msg(v, c);
         if ($urandom_range(1) == 1) begin
            v = 4'($urandom_range(15));
            if (v == cur) v = v + 4'd1;
            fork
               recv_msg($sformatf("r%0d", it), 1);
               begin
                  repeat ($urandom_range(3, 20)) @(negedge clk);
                  count_in = v;
               end
            join
            cur = v;
            expect_msg(v, c);
            recv_msg($sformatf("r%0dp", it), 1);
         end else begin
            recv_msg($sformatf("r%0d", it), 1);
         end
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      chk("rand_ovr", 32'(overrun), 32'd0);
      quiet("end_idle", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
